// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU execution controller: instruction
// field layout, flag bit positions and FSM state encoding.
package alu4_pkg;

  localparam int INSTR_W     = 16;
  localparam int OP_LSB      = 0;
  localparam int OP_W        = 4;
  localparam int DST_LSB     = 4;
  localparam int SRCA_LSB    = 6;
  localparam int SRCB_LSB    = 8;
  localparam int SEL_W       = 2;
  localparam int IMM_LSB     = 10;
  localparam int IMM_W       = 4;
  localparam int USE_IMM_BIT = 14;
  localparam int WB_EN_BIT   = 15;

  localparam int FLAGS_W = 4;
  localparam int FLAG_C  = 0;
  localparam int FLAG_RC = 1;
  localparam int FLAG_V  = 2;
  localparam int FLAG_Z  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu4_regfile.sv
// Small register file: two asynchronous read ports, one synchronous write
// port, every entry cleared by the asynchronous reset.
module alu4_regfile #(
  parameter int WIDTH = 4,
  parameter int NREG  = 4,
  parameter int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] regs_q [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/alu4_exec_ctrl.sv
// Sequencing/writeback stage around an external 4-bit combinational ALU:
// accept instruction, drive registered operands, capture result and flags.
module alu4_exec_ctrl
  import alu4_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREG  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [OP_W-1:0]    alu_op,
  output logic               alu_cin,
  output logic               alu_rcin,
  input  logic [WIDTH-1:0]   alu_y,
  input  logic               alu_co,
  input  logic               alu_rco,
  input  logic               alu_v,
  input  logic               alu_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [FLAGS_W-1:0] out_flags,
  output logic [FLAGS_W-1:0] flags,
  output logic [1:0]         dbg_state
);

  localparam int AW = $clog2(NREG);

  state_t             state_q, state_d;
  logic               live_q;
  logic [AW-1:0]      dst_q;
  logic               wb_en_q;
  logic [WIDTH-1:0]   alu_a_q, alu_b_q;
  logic [OP_W-1:0]    alu_op_q;
  logic               alu_cin_q, alu_rcin_q;
  logic [FLAGS_W-1:0] flags_q, out_flags_q;
  logic [WIDTH-1:0]   out_data_q;
  logic [WIDTH-1:0]   rd_a, rd_b;
  logic [FLAGS_W-1:0] new_flags;
  logic               rf_we, accept;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE (and not before the first edge after reset);
  // out_valid is high only in RESP and the result holds until out_ready.
  assign accept    = in_valid & in_ready;
  assign new_flags = {alu_z, alu_v, alu_rco, alu_co};

  alu4_regfile #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (dst_q),
    .wdata   (alu_y),
    .raddr_a (in_instr[SRCA_LSB +: SEL_W]),
    .rdata_a (rd_a),
    .raddr_b (in_instr[SRCB_LSB +: SEL_W]),
    .rdata_b (rd_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rf_we     = 1'b0;
    unique case (state_q)
      ST_IDLE: in_ready  = live_q;
      ST_EXEC: rf_we     = wb_en_q;
      ST_RESP: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operands are read at accept, so a write to the same entry in EXEC
  // never feeds back into the instruction that produced it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q      <= 1'b0;
      dst_q       <= '0;
      wb_en_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_cin_q   <= 1'b0;
      alu_rcin_q  <= 1'b0;
      flags_q     <= '0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else begin
      live_q <= 1'b1;
      if (accept) begin
        dst_q      <= in_instr[DST_LSB +: SEL_W];
        wb_en_q    <= in_instr[WB_EN_BIT];
        alu_op_q   <= in_instr[OP_LSB +: OP_W];
        alu_a_q    <= rd_a;
        alu_b_q    <= in_instr[USE_IMM_BIT] ? WIDTH'(in_instr[IMM_LSB +: IMM_W]) : rd_b;
        alu_cin_q  <= flags_q[FLAG_C];
        alu_rcin_q <= flags_q[FLAG_RC];
      end
      if (state_q == ST_EXEC) begin
        flags_q     <= new_flags;
        out_data_q  <= alu_y;
        out_flags_q <= new_flags;
      end
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_cin   = alu_cin_q;
  assign alu_rcin  = alu_rcin_q;
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;
  assign flags     = flags_q;
  assign dbg_state = state_q;

endmodule

// File: doc/alu4_exec_ctrl.md
# alu4_exec_ctrl

Instruction-sequencing and writeback stage that wraps the 4-bit combinational ALU. It accepts 16-bit instructions over a valid/ready handshake, reads two operands from a 4-entry register file, drives the ALU's operand, opcode and carry inputs from registers, and captures the ALU result and flags one cycle later. It writes the result back to the register file, updates the architectural flag register, and presents the result downstream over a second valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 4, datapath width; must match the ALU.
- `NREG`, 4, register-file entries; index width is clog2(NREG)=2.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: block can accept an instruction.
- `in_instr` in 16: [3:0] op, [5:4] dst, [7:6] srcA, [9:8] srcB, [13:10] imm, [14] use_imm, [15] wb_en.
- `alu_a`, `alu_b` out WIDTH: registered operands to the ALU.
- `alu_op` out 4: registered opcode to the ALU.
- `alu_cin`, `alu_rcin` out 1: registered math/rotate carry-ins, taken from flags C/RC.
- `alu_y` in WIDTH: ALU result.
- `alu_co`, `alu_rco`, `alu_v`, `alu_z` in 1: ALU math carry, rotate carry, overflow, zero.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out WIDTH: captured result.
- `out_flags` out 4: {Z,V,RC,C} after this instruction.
- `flags` out 4: architectural flag register {Z,V,RC,C}.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch op/dst/wb_en, and set `alu_a`=R[srcA].
  - Set `alu_b` = use_imm ? imm : R[srcB].
  - Set `alu_cin`=flags.C and `alu_rcin`=flags.RC.
  - Go to EXEC.
- **EXEC** (exactly one cycle)
  - ALU outputs are sampled at the end of the cycle.
  - flags <= {alu_z, alu_v, alu_rco, alu_co}, unconditionally.
  - If wb_en: R[dst] <= alu_y.
  - `out_data` <= alu_y and `out_flags` <= the new flags.
  - Go to RESP.
- **RESP**
  - `out_valid`=1.
  - Hold `out_data`/`out_flags` stable until `out_ready`, then go to IDLE.
- `in_ready`=0 in EXEC and RESP. `in_valid` there is ignored; no buffering and no instruction loss, because the upstream producer must hold it.
- Operands are captured at accept, so dst==srcA/srcB reads the old value (read-before-write).
- `alu_*` outputs hold their last value outside EXEC.
- Register-file writes happen only in EXEC; there is no other write path.

## Timing
- Reset values:
  - State = IDLE.
  - All R[i]=0 and flags=0.
  - `alu_a`=`alu_b`=`alu_op`=0 and `alu_cin`=`alu_rcin`=0.
  - `out_data`=0, `out_flags`=0 and `out_valid`=0.
  - `in_ready`=0 while `rst` is high, and 1 on the first edge after release.
- Latency: accept at edge N, ALU sampled at edge N+1, `out_valid` high from N+1.
- Best-case throughput is one instruction per 3 cycles: `out_ready` tied high gives IDLE→EXEC→RESP→IDLE.
- The ALU path (operand regs → ALU → flag/regfile regs) is a single-cycle combinational path.
- `rst` mid-EXEC or mid-RESP aborts immediately: no writeback, flags cleared, result discarded.
- Simultaneous `out_ready` in RESP and `in_valid`: the instruction is not accepted that cycle; it is accepted in the following IDLE cycle.

## Structure
- Package `alu4_pkg`:
  - Instruction field offsets/widths.
  - FSM state enum {IDLE, EXEC, RESP}.
  - Flag bit indices C=0, RC=1, V=2, Z=3.
- Sub-module `alu4_regfile`:
  - NREG×WIDTH entries, 2 asynchronous read ports, 1 synchronous write port.
  - Async reset to 0.
- The ALU itself is not instantiated here; it connects externally via the `alu_*` ports.

## Test plan
For all scenarios the bench stubs the ALU with a scoreboard model.

- **Reset:** `rst` pulse mid-RESP → `out_valid`=0, `flags`=0, all R=0, `in_ready`=1 one cycle after release.
- **Immediate writeback:** instr use_imm=1, imm=4'hA, op=4'h3, wb_en=1, dst=2, stub `alu_y`=4'h7, flags in=1001b → `alu_b`=A in EXEC; next cycle `out_data`=7, `out_flags`=1001b; R[2]=7.
- **Read-before-write:** R1=5, instr srcA=1, dst=1 → `alu_a`=5 in EXEC; R1 updates only at the EXEC edge.
- **Backpressure:** `out_ready` low for 4 cycles → `out_valid` and `out_data` stable for 4 cycles; `in_valid` during this is not accepted (`in_ready`=0).
- **Carry chaining:** first instr leaves C=1, RC=0 → second instr drives `alu_cin`=1, `alu_rcin`=0.
- **wb_en=0:** R unchanged, flags still updated, `out_valid` still asserted.
